// File: rtl/pinmux_pkg.sv
// Select-encoding constants and commit FSM state type shared by the pinmux.
// Pure declarations; no latency or flow control of its own.
package pinmux_pkg;

  localparam int unsigned InTie0        = 0;
  localparam int unsigned InTie1        = 1;
  localparam int unsigned InPadBase     = 2;

  localparam int unsigned OutTie0       = 0;
  localparam int unsigned OutTie1       = 1;
  localparam int unsigned OutHiZ        = 2;
  localparam int unsigned OutPeriphBase = 3;

  typedef enum logic [1:0] {
    CommitIdle   = 2'd0,
    CommitApply  = 2'd1,
    CommitSettle = 2'd2
  } commit_state_e;

endpackage

// File: rtl/prim_flop_2sync.sv
// Two-flop synchroniser for pad inputs: 2-cycle latency, resets to 0.
// No flow control; samples every cycle.
module prim_flop_2sync #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  logic [Width-1:0] meta;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pinmux_cfg_mux.sv
// Pinmux with shadow/active select tables; pads out 1 cycle registered, pads in 2 cycles (0 if bypassed).
// No backpressure: illegal or locked writes pulse cfg_err_o, commits while busy are dropped.
module pinmux_cfg_mux
  import pinmux_pkg::*;
#(
  parameter int unsigned NPeriphIn  = 32,
  parameter int unsigned NPeriphOut = 32,
  parameter int unsigned NMioPads   = 32,
  parameter int unsigned SyncIn     = 1,
  localparam int unsigned InSelW    = $clog2(NMioPads + 2),
  localparam int unsigned OutSelW   = $clog2(NPeriphOut + 3),
  localparam int unsigned AddrW     = $clog2(NPeriphIn + NMioPads),
  localparam int unsigned DataW     = (InSelW > OutSelW) ? InSelW : OutSelW
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cfg_we_i,
  input  logic [AddrW-1:0]      cfg_addr_i,
  input  logic [DataW-1:0]      cfg_wdata_i,
  input  logic                  cfg_commit_i,
  input  logic                  cfg_lock_i,
  output logic                  cfg_err_o,
  output logic                  cfg_busy_o,
  output logic                  locked_o,
  input  logic [NPeriphOut-1:0] periph_to_mio_i,
  input  logic [NPeriphOut-1:0] periph_to_mio_oe_i,
  output logic [NPeriphIn-1:0]  mio_to_periph_o,
  output logic [NMioPads-1:0]   mio_out_o,
  output logic [NMioPads-1:0]   mio_oe_o,
  input  logic [NMioPads-1:0]   mio_in_i
);

  logic [InSelW-1:0]  insel_sh   [NPeriphIn];
  logic [InSelW-1:0]  insel_act  [NPeriphIn];
  logic [OutSelW-1:0] outsel_sh  [NMioPads];
  logic [OutSelW-1:0] outsel_act [NMioPads];

  commit_state_e       state, state_next;
  logic                in_hit, out_hit, wr_ok, wr_bad;
  logic [NMioPads-1:0] pad_in, pad_out, pad_oe;

  if (SyncIn != 0) begin : g_sync
    prim_flop_2sync #(.Width(NMioPads)) u_sync (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d      (mio_in_i),
      .q      (pad_in)
    );
  end else begin : g_bypass
    assign pad_in = mio_in_i;
  end

  // Address decode by equality so no comparison degenerates when the map fills the address space.
  always_comb begin
    in_hit  = 1'b0;
    out_hit = 1'b0;
    for (int i = 0; i < NPeriphIn; i++)
      if (cfg_addr_i == AddrW'(i)) in_hit = 1'b1;
    for (int i = 0; i < NMioPads; i++)
      if (cfg_addr_i == AddrW'(NPeriphIn + i)) out_hit = 1'b1;
    wr_ok  = cfg_we_i && !locked_o &&
             ((in_hit  && (cfg_wdata_i <= DataW'(NMioPads + 1))) ||
              (out_hit && (cfg_wdata_i <= DataW'(NPeriphOut + 2))));
    wr_bad = cfg_we_i && !wr_ok;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NPeriphIn; i++) insel_sh[i]  <= InSelW'(InTie0);
      for (int i = 0; i < NMioPads; i++)  outsel_sh[i] <= OutSelW'(OutHiZ);
    end else if (wr_ok) begin
      for (int i = 0; i < NPeriphIn; i++)
        if (cfg_addr_i == AddrW'(i)) insel_sh[i] <= cfg_wdata_i[InSelW-1:0];
      for (int i = 0; i < NMioPads; i++)
        if (cfg_addr_i == AddrW'(NPeriphIn + i)) outsel_sh[i] <= cfg_wdata_i[OutSelW-1:0];
    end
  end

  // Shadow writes landing in the APPLY cycle miss this copy: both are sampled on the same edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NPeriphIn; i++) insel_act[i]  <= InSelW'(InTie0);
      for (int i = 0; i < NMioPads; i++)  outsel_act[i] <= OutSelW'(OutHiZ);
    end else if (state == CommitApply) begin
      insel_act  <= insel_sh;
      outsel_act <= outsel_sh;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= CommitIdle;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    cfg_busy_o = 1'b1;
    unique case (state)
      CommitIdle: begin
        cfg_busy_o = 1'b0;
        if (cfg_commit_i) state_next = CommitApply;
      end
      CommitApply:  state_next = CommitSettle;
      CommitSettle: state_next = CommitIdle;
      default:      state_next = CommitIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      locked_o  <= 1'b0;
      cfg_err_o <= 1'b0;
    end else begin
      locked_o  <= locked_o | cfg_lock_i;
      cfg_err_o <= wr_bad;
    end
  end

  always_comb begin
    pad_out = '0;
    pad_oe  = '0;
    for (int p = 0; p < NMioPads; p++) begin
      if (outsel_act[p] == OutSelW'(OutTie0)) begin
        pad_oe[p] = 1'b1;
      end else if (outsel_act[p] == OutSelW'(OutTie1)) begin
        pad_out[p] = 1'b1;
        pad_oe[p]  = 1'b1;
      end else begin
        for (int k = 0; k < NPeriphOut; k++)
          if (outsel_act[p] == OutSelW'(OutPeriphBase + k)) begin
            pad_out[p] = periph_to_mio_i[k];
            pad_oe[p]  = periph_to_mio_oe_i[k];
          end
      end
    end
  end

  always_comb begin
    mio_to_periph_o = '0;
    for (int i = 0; i < NPeriphIn; i++) begin
      if (insel_act[i] == InSelW'(InTie1)) begin
        mio_to_periph_o[i] = 1'b1;
      end else begin
        for (int j = 0; j < NMioPads; j++)
          if (insel_act[i] == InSelW'(InPadBase + j)) mio_to_periph_o[i] = pad_in[j];
      end
    end
  end

  // SETTLE freezes the pads so the table swap never glitches them.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mio_out_o <= '0;
      mio_oe_o  <= '0;
    end else if (state != CommitSettle) begin
      mio_out_o <= pad_out;
      mio_oe_o  <= pad_oe;
    end
  end

endmodule

// File: tb/tb_pinmux_cfg_mux.sv
// Randomised scoreboard bench for pinmux_cfg_mux against a table-level reference model.
module tb_pinmux_cfg_mux;

  localparam int NPI = 30;
  localparam int NPO = 32;
  localparam int NMP = 32;
  localparam int AW  = 6;
  localparam int DW  = 6;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           cfg_we = 1'b0, cfg_commit = 1'b0, cfg_lock = 1'b0;
  logic [AW-1:0]  cfg_addr = '0;
  logic [DW-1:0]  cfg_wdata = '0;
  logic           cfg_err, cfg_busy, locked;
  logic [NPO-1:0] p2m = '0, p2m_oe = '0;
  logic [NPI-1:0] m2p;
  logic [NMP-1:0] mio_out, mio_oe;
  logic [NMP-1:0] mio_in = '0;

  pinmux_cfg_mux #(.NPeriphIn(NPI), .NPeriphOut(NPO), .NMioPads(NMP), .SyncIn(1)) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .cfg_we_i           (cfg_we),
    .cfg_addr_i         (cfg_addr),
    .cfg_wdata_i        (cfg_wdata),
    .cfg_commit_i       (cfg_commit),
    .cfg_lock_i         (cfg_lock),
    .cfg_err_o          (cfg_err),
    .cfg_busy_o         (cfg_busy),
    .locked_o           (locked),
    .periph_to_mio_i    (p2m),
    .periph_to_mio_oe_i (p2m_oe),
    .mio_to_periph_o    (m2p),
    .mio_out_o          (mio_out),
    .mio_oe_o           (mio_oe),
    .mio_in_i           (mio_in)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int             due;
    logic [NMP-1:0] out;
    logic [NMP-1:0] oe;
    logic [NPI-1:0] per;
    logic           err;
    logic           busy;
    logic           locked;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: tables as integer arrays, a commit as a snapshot plus a countdown.
  int             sh_in[NPI], sh_out[NMP], act_in[NPI], act_out[NMP], snap_in[NPI], snap_out[NMP];
  int             busy_left;
  bit             m_locked, m_err;
  logic [NMP-1:0] m_out, m_oe, s1, s2;
  logic [31:0]    pmask = '0;

  task automatic model_reset();
    for (int i = 0; i < NPI; i++) begin sh_in[i] = 0; act_in[i] = 0; end
    for (int i = 0; i < NMP; i++) begin sh_out[i] = 2; act_out[i] = 2; end
    busy_left = 0; m_locked = 0; m_err = 0;
    m_out = '0; m_oe = '0; s1 = '0; s2 = '0;
  endtask

  task automatic model_edge(input bit we, input int addr, input int wd, input bit commit, input bit lock,
                            input logic [NPO-1:0] pd, input logic [NPO-1:0] poe, input logic [NMP-1:0] min);
    bit legal;
    if (busy_left != 1)
      for (int p = 0; p < NMP; p++)
        case (act_out[p])
          0:       begin m_out[p] = 1'b0; m_oe[p] = 1'b1; end
          1:       begin m_out[p] = 1'b1; m_oe[p] = 1'b1; end
          2:       begin m_out[p] = 1'b0; m_oe[p] = 1'b0; end
          default: begin m_out[p] = pd[act_out[p]-3]; m_oe[p] = poe[act_out[p]-3]; end
        endcase
    if (busy_left == 2) begin act_in = snap_in; act_out = snap_out; end
    if (addr < NPI)            legal = (wd <= NMP + 1);
    else if (addr < NPI + NMP) legal = (wd <= NPO + 2);
    else                       legal = 0;
    m_err = we && (!legal || m_locked);
    if (we && legal && !m_locked) begin
      if (addr < NPI) sh_in[addr] = wd;
      else            sh_out[addr-NPI] = wd;
    end
    if (busy_left > 0) busy_left--;
    else if (commit) begin snap_in = sh_in; snap_out = sh_out; busy_left = 2; end
    if (lock) m_locked = 1;
    s2 = s1;
    s1 = min;
  endtask

  function automatic exp_t expect_at(input int due);
    exp_t e;
    e.due = due; e.out = m_out; e.oe = m_oe;
    e.err = m_err; e.busy = (busy_left > 0); e.locked = m_locked;
    for (int i = 0; i < NPI; i++)
      case (act_in[i])
        0:       e.per[i] = 1'b0;
        1:       e.per[i] = 1'b1;
        default: e.per[i] = s2[act_in[i]-2];
      endcase
    return e;
  endfunction

  task automatic step(input bit rst, input bit we, input int addr, input int wd, input bit commit, input bit lock,
                      input logic [NPO-1:0] pd, input logic [NPO-1:0] poe, input logic [NMP-1:0] min);
    @(posedge clk);
    #1;
    rst_n = rst; cfg_we = we; cfg_addr = AW'(addr); cfg_wdata = DW'(wd);
    cfg_commit = commit; cfg_lock = lock; p2m = pd; p2m_oe = poe; mio_in = min;
    if (!rst) begin
      model_reset();
      while (sb.size() > 0 && sb[$].due >= cyc) void'(sb.pop_back());
      sb.push_back(expect_at(cyc));
    end else begin
      model_edge(we, addr, wd, commit, lock, pd, poe, min);
    end
    sb.push_back(expect_at(cyc + 1));
  endtask

  task automatic go(input bit we, input int addr, input int wd, input bit commit, input bit lock);
    step(1'b1, we, addr, wd, commit, lock, $urandom | pmask, $urandom | pmask, $urandom);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) go(0, 0, 0, 0, 0);
  endtask

  task automatic rst_cycles(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 0, 0, 0, 0, 0, '0, '0, '0);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        if (e.due < cyc) begin
          checks++;
          errors++;
          $display("FAIL stale_expectation due %0d seen at cycle %0d", e.due, cyc);
        end else begin
          chk("mio_out", 64'(mio_out), 64'(e.out));
          chk("mio_oe", 64'(mio_oe), 64'(e.oe));
          chk("mio_to_periph", 64'(m2p), 64'(e.per));
          chk("cfg_err", 64'(cfg_err), 64'(e.err));
          chk("cfg_busy", 64'(cfg_busy), 64'(e.busy));
          chk("locked", 64'(locked), 64'(e.locked));
        end
      end
    end
  end

  initial begin : driver
    model_reset();
    rst_cycles(3);
    idle(3);

    // Pad 3 driven by peripheral 2 (held high); nothing changes until the commit lands.
    pmask = 32'h4;
    go(1, NPI + 3, 5, 0, 0);
    idle(3);
    go(0, 0, 0, 1, 0);
    idle(5);
    pmask = '0;

    // Peripheral 0 fed from pad 7; toggle pad 7 to see the 2-cycle sync path.
    go(1, 0, 9, 0, 0);
    go(0, 0, 0, 1, 0);
    idle(3);
    for (int k = 0; k < 8; k++)
      step(1'b1, 0, 0, 0, 0, 0, $urandom, $urandom, NMP'(k % 2) << 7);

    // Illegal values and addresses, then a commit to expose any shadow corruption.
    go(1, 0, NMP + 2, 0, 0);
    go(1, NPI + NMP, 3, 0, 0);
    go(1, NPI + NMP + 1, 1, 0, 0);
    go(1, NPI + 5, NPO + 3, 0, 0);
    go(0, 0, 0, 1, 0);
    idle(4);

    // Same-cycle write and commit; then reset in the middle of APPLY.
    go(1, NPI + 7, 3, 1, 0);
    idle(4);
    go(1, 1, 5, 1, 0);
    rst_cycles(2);
    idle(3);

    for (int k = 0; k < 2000; k++)
      go($urandom_range(0, 1),
         ($urandom_range(0, 7) == 0) ? int'($urandom_range(60, 63)) : int'($urandom_range(0, 61)),
         ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 36)),
         $urandom_range(0, 7) == 0, 0);

    // Lock: writes rejected, commits still allowed; only reset unlocks.
    go(0, 0, 0, 0, 1);
    go(1, NPI + 3, 0, 0, 0);
    go(1, 2, 4, 0, 0);
    go(0, 0, 0, 1, 0);
    for (int k = 0; k < 200; k++)
      go($urandom_range(0, 1), $urandom_range(0, 61), $urandom_range(0, 34), $urandom_range(0, 5) == 0, 0);
    rst_cycles(2);
    idle(3);

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
